// File: rtl/bist_misr_analyzer.sv
// MISR output response analyzer for the ALU BIST loop.
// Optional abort port enabled by defining BIST_MISR_ABORT_EN.
module bist_misr_analyzer #(
  parameter int              WIDTH         = 9,
  parameter int              PATTERN_COUNT = 256,
  parameter logic [WIDTH-1:0] POLY         = 9'h011,
  parameter logic [WIDTH-1:0] MISR_SEED    = 9'h000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef BIST_MISR_ABORT_EN
  input  logic             abort,
`endif
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  input  logic [WIDTH-1:0] golden_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [15:0]      pattern_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    COMPARE,
    DONE
  } state_t;

  localparam logic [15:0] LAST = 16'(PATTERN_COUNT - 1);

  state_t           state;
  logic [WIDTH-1:0] next_sig;
  logic             kill;

  // Galois step: shift left, fold the MSB back through the taps.
  assign next_sig = {signature[WIDTH-2:0], 1'b0}
                  ^ (signature[WIDTH-1] ? POLY : '0)
                  ^ resp_data;

`ifdef BIST_MISR_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      signature   <= MISR_SEED;
      pattern_cnt <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            signature   <= MISR_SEED;
            pattern_cnt <= '0;
            pass        <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        RUN: begin
          if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else if (resp_valid) begin
            signature   <= next_sig;
            pattern_cnt <= pattern_cnt + 16'd1;
            if (pattern_cnt == LAST)
              state <= COMPARE;
          end
        end
        COMPARE: begin
          if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            state <= DONE;
            pass  <= (signature == golden_sig);
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
